// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = x1 - x2 - bin, with borrow out.
module full_subtractor (
    input  logic x1,
    input  logic x2,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Pure combinational cell, evaluated once per serial step.
    always_comb begin
        diff = x1 ^ x2 ^ bin;
        bout = (~x1 & x2) | (~(x1 ^ x2) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor with valid/ready handshakes on both sides.
// Operands are captured in IDLE, processed LSB first over WIDTH cycles in
// SHIFT, and the result is presented in HOLD until the consumer takes it.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             cell_diff;
    logic             cell_bout;
    logic             last_bit;
    logic [WIDTH:0]   sh_ext;

    full_subtractor u_cell (
        .x1   (a_q[0]),
        .x2   (b_q[0]),
        .bin  (borrow_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // Result bits enter at the MSB; the extra top bit keeps WIDTH=1 legal.
    assign sh_ext   = {cell_diff, sh_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // Next-state and datapath update; the visible result only changes when
    // the final bit completes, so diff/bout stay put during SHIFT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = cell_bout;
                sh_d     = sh_ext[WIDTH:1];
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    diff_d  = sh_ext[WIDTH:1];
                    bout_d  = cell_bout;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        diff      = diff_q;
        bout      = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv    [2];
    logic [7:0] av_s  [2];
    logic [7:0] bv_s  [2];
    logic       bi_s  [2];
    logic       ordy  [2];
    int         rmode [2];

    logic       ir0, ov0, bo0;
    logic [7:0] df0;
    logic       ir1, ov1, bo1;
    logic [0:0] df1;
    logic [0:0] a1, b1;

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign a1 = av_s[1][0];
    assign b1 = bv_s[1][0];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[0]),
        .in_ready  (ir0),
        .a         (av_s[0]),
        .b         (bv_s[0]),
        .bin       (bi_s[0]),
        .out_valid (ov0),
        .out_ready (ordy[0]),
        .diff      (df0),
        .bout      (bo0)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[1]),
        .in_ready  (ir1),
        .a         (a1),
        .b         (b1),
        .bin       (bi_s[1]),
        .out_valid (ov1),
        .out_ready (ordy[1]),
        .diff      (df1),
        .bout      (bo1)
    );

    // Reference: plain integer subtraction, wrapped modulo 2^w.
    function automatic logic [8:0] model(input int w, input int av, input int bv, input int bi);
        int r;
        int m;
        int dv;
        m  = 1 << w;
        r  = av - bv - bi;
        dv = (r + m) % m;
        return {(r < 0), 8'(dv)};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic check_out(input int d, input logic [7:0] dv, input logic bv, input logic take);
        logic [8:0] e;
        int         have;
        have = (d == 0) ? q0.size() : q1.size();
        checks++;
        if (have == 0) begin
            errors++;
            $display("FAIL out_unexpected dut%0d: got diff=%0h bout=%0b, required no output", d, dv, bv);
        end else begin
            e = (d == 0) ? q0[0] : q1[0];
            if ({bv, dv} !== e) begin
                errors++;
                $display("FAIL result dut%0d: got diff=%0h bout=%0b, required diff=%0h bout=%0b",
                         d, dv, bv, e[7:0], e[8]);
            end
            if (take) begin
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    // Monitor: every cycle a result is shown it must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov0) check_out(0, df0, bo0, ordy[0]);
            if (ov1) check_out(1, {7'b0, df1}, bo1, ordy[1]);
        end
    end

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rmode[d] == 1) ordy[d] = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int d, input int av, input int bv, input int bi);
        logic r;
        int   ok;
        int   w;
        w  = (d == 0) ? 8 : 1;
        av = av & ((1 << w) - 1);
        bv = bv & ((1 << w) - 1);
        iv[d]   = 1'b1;
        av_s[d] = 8'(av);
        bv_s[d] = 8'(bv);
        bi_s[d] = 1'(bi);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            r = (d == 0) ? ir0 : ir1;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1;
                break;
            end
        end
        iv[d] = 1'b0;
        if (ok == 1) begin
            if (d == 0) q0.push_back(model(w, av, bv, bi));
            else        q1.push_back(model(w, av, bv, bi));
        end else begin
            chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic drain(input int d);
        int k;
        k = 0;
        while (((d == 0) ? q0.size() : q1.size()) > 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain", (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic rand_drv(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(d, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; av_s[d] = '0; bv_s[d] = '0; bi_s[d] = 1'b0;
            ordy[d] = 1'b1; rmode[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready8", int'(ir0), 1);
        chk("rst_out_valid8", int'(ov0), 0);
        chk("rst_diff8", int'(df0), 0);
        chk("rst_bout8", int'(bo0), 0);
        chk("rst_in_ready1", int'(ir1), 1);
        chk("rst_out_valid1", int'(ov1), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 200 - 55 with latency measured from the acceptance edge.
        send(0, 200, 55, 0);
        n = 0;
        while (!ov0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_8", n, 8);
        drain(0);

        send(0, 8'h00, 8'h01, 0); drain(0);
        send(0, 8'h05, 8'h05, 1); drain(0);
        send(0, 8'h80, 8'h7F, 1); drain(0);
        send(1, 0, 1, 1);         drain(1);
        send(1, 1, 0, 0);         drain(1);

        // Backpressure: result held while new operands are offered.
        ordy[0] = 1'b0;
        send(0, 8'hA5, 8'h3C, 0);
        n = 0;
        while (!ov0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            iv[0]   = 1'b1;
            av_s[0] = 8'($urandom);
            bv_s[0] = 8'($urandom);
            bi_s[0] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("bp_in_ready", int'(ir0), 0);
            chk("bp_out_valid", int'(ov0), 1);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        drain(0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        chk("bp_no_capture_valid", int'(ov0), 0);
        chk("bp_no_capture_ready", int'(ir0), 1);

        // Reset after four bits processed aborts the operation.
        send(0, 8'hAB, 8'h12, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        chk("abort_out_valid", int'(ov0), 0);
        chk("abort_in_ready", int'(ir0), 1);
        send(0, 8'h10, 8'h01, 0);
        drain(0);

        // Random sweep on both widths with random gaps and backpressure.
        rmode[0] = 1;
        rmode[1] = 1;
        fork
            rand_drv(0, 500);
            rand_drv(1, 500);
        join
        rmode[0] = 0;
        rmode[1] = 0;
        @(posedge clk);
        #2;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        drain(0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
